// File: rtl/ctrl_pkg.sv
// rtl/ctrl_pkg.sv - microinstruction field layout and sequencer encodings
package ctrl_pkg;

    localparam int UADDR_W  = 7;
    localparam int UINSTR_W = 45;
    localparam int CR_LSB   = 0;
    localparam int NS_LSB   = 7;
    localparam int CS_LSB   = 10;
    localparam int INV_BIT  = 13;
    localparam int CTRL_LSB = 14;
    localparam int CTRL_W   = UINSTR_W - CTRL_LSB;
    localparam int WCNT_W   = 8;

    typedef enum logic [2:0] {
        NS_INC  = 3'd0,
        NS_JMP  = 3'd1,
        NS_BR   = 3'd2,
        NS_DISP = 3'd3,
        NS_CALL = 3'd4,
        NS_RET  = 3'd5,
        NS_WAIT = 3'd6,
        NS_RST  = 3'd7
    } ns_e;

    typedef enum logic [2:0] {
        CS_ONE    = 3'd0,
        CS_MOC    = 3'd1,
        CS_CCZ    = 3'd2,
        CS_CPASS  = 3'd3,
        CS_DVALID = 3'd4,
        CS_RSV5   = 3'd5,
        CS_RSV6   = 3'd6,
        CS_RSV7   = 3'd7
    } cs_e;

endpackage

// File: rtl/ustack.sv
// rtl/ustack.sv - return-address LIFO for microsubroutine calls
module ustack
    import ctrl_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int SP_W  = $clog2(DEPTH + 1),
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               push,
    input  logic               pop,
    input  logic [UADDR_W-1:0] din,
    output logic [UADDR_W-1:0] dout,
    output logic [SP_W-1:0]    sp,
    output logic               full,
    output logic               empty
);

    logic [UADDR_W-1:0] mem [DEPTH];
    logic [AW-1:0]      wr_ptr;
    logic [AW-1:0]      top_ptr;

    assign full    = (sp == SP_W'(DEPTH));
    assign empty   = (sp == '0);
    assign wr_ptr  = sp[AW-1:0];
    assign top_ptr = AW'(sp - 1'b1);
    assign dout    = mem[top_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sp <= '0;
        end else if (push && !full) begin
            sp <= sp + 1'b1;
        end else if (pop && !empty) begin
            sp <= sp - 1'b1;
        end
    end

    // Contents are don't-care after reset, so the array carries no reset.
    always_ff @(posedge clk) begin
        if (push && !full) begin
            mem[wr_ptr] <= din;
        end
    end

endmodule

// File: rtl/microsequencer.sv
// rtl/microsequencer.sv - micro-PC, next-address select, wait timer and error flags
module microsequencer
    import ctrl_pkg::*;
#(
    parameter int STACK_DEPTH = 4,
    parameter int WAIT_LIMIT  = 255
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [UINSTR_W-1:0] uinstr,
    input  logic                moc,
    input  logic                cond_pass,
    input  logic                ccz,
    input  logic [UADDR_W-1:0]  decode_addr,
    input  logic                decode_valid,
    input  logic                stall,
    output logic [UADDR_W-1:0]  index,
    output logic [CTRL_W-1:0]   ctrl,
    output logic                waiting,
    output logic                stk_ovf,
    output logic                stk_unf,
    output logic                wait_tmo
);

    localparam int SP_W = $clog2(STACK_DEPTH + 1);
    localparam logic [WCNT_W-1:0] WAIT_MAX = WCNT_W'(WAIT_LIMIT);

    ns_e                ns;
    cs_e                cs;
    logic [UADDR_W-1:0] cr;
    logic [UADDR_W-1:0] inc;
    logic [UADDR_W-1:0] next_index;
    logic [UADDR_W-1:0] ret_addr;
    logic [WCNT_W-1:0]  wait_cnt;
    logic [WCNT_W-1:0]  cnt_next;
    logic [SP_W-1:0]    stk_sp_unused;
    logic               sel;
    logic               cond;
    logic               push;
    logic               pop;
    logic               full;
    logic               empty;
    logic               set_ovf;
    logic               set_unf;
    logic               set_tmo;

    assign ctrl = uinstr[UINSTR_W-1:CTRL_LSB];
    assign ns   = ns_e'(uinstr[NS_LSB +: 3]);
    assign cs   = cs_e'(uinstr[CS_LSB +: 3]);
    assign cr   = uinstr[CR_LSB +: UADDR_W];
    assign inc  = index + 1'b1;

    always_comb begin
        sel = 1'b0;
        case (cs)
            CS_ONE:    sel = 1'b1;
            CS_MOC:    sel = moc;
            CS_CCZ:    sel = ccz;
            CS_CPASS:  sel = cond_pass;
            CS_DVALID: sel = decode_valid;
            default:   sel = 1'b0;
        endcase
        cond = sel ^ uinstr[INV_BIT];
    end

    always_comb begin
        next_index = inc;
        cnt_next   = wait_cnt;
        waiting    = 1'b0;
        push       = 1'b0;
        pop        = 1'b0;
        set_ovf    = 1'b0;
        set_unf    = 1'b0;
        set_tmo    = 1'b0;
        case (ns)
            NS_INC: next_index = inc;
            NS_JMP: next_index = cr;
            NS_BR:  next_index = cond ? cr : inc;
            NS_DISP: begin
                if (decode_valid) begin
                    next_index = decode_addr;
                end else begin
                    next_index = index;
                    waiting    = 1'b1;
                end
            end
            NS_CALL: begin
                next_index = cr;
                push       = !full;
                set_ovf    = full;
            end
            NS_RET: begin
                next_index = empty ? '0 : ret_addr;
                pop        = !empty;
                set_unf    = empty;
            end
            NS_WAIT: begin
                if (moc) begin
                    cnt_next = '0;
                end else if (wait_cnt == WAIT_MAX) begin
                    // Counter has already spent WAIT_LIMIT extra cycles: abandon the access.
                    next_index = '0;
                    cnt_next   = '0;
                    set_tmo    = 1'b1;
                    waiting    = 1'b1;
                end else begin
                    next_index = index;
                    cnt_next   = wait_cnt + 1'b1;
                    waiting    = 1'b1;
                end
            end
            NS_RST: begin
                next_index = '0;
                cnt_next   = '0;
            end
            default: next_index = inc;
        endcase
    end

    ustack #(
        .DEPTH (STACK_DEPTH)
    ) u_stack (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push && !stall),
        .pop   (pop && !stall),
        .din   (inc),
        .dout  (ret_addr),
        .sp    (stk_sp_unused),
        .full  (full),
        .empty (empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            index    <= '0;
            wait_cnt <= '0;
            stk_ovf  <= 1'b0;
            stk_unf  <= 1'b0;
            wait_tmo <= 1'b0;
        end else if (!stall) begin
            index    <= next_index;
            wait_cnt <= cnt_next;
            stk_ovf  <= stk_ovf | set_ovf;
            stk_unf  <= stk_unf | set_unf;
            wait_tmo <= wait_tmo | set_tmo;
        end
    end

endmodule

// File: doc/microsequencer.md
# microsequencer

Control-unit microsequencer for the ARM simulator. It drives the 7-bit microstore index and receives the 45-bit microinstruction back combinationally in the same cycle. It then selects the next microaddress from one of several sources: increment, jump, conditional branch, opcode dispatch, subroutine call/return, memory-wait, or restart. The datapath control field passes straight through to the datapath.

## Interface
Parameters:
- `STACK_DEPTH`, 4: return-address stack entries (power of two, 2..8).
- `WAIT_LIMIT`, 255: maximum cycles spent in a memory wait before timeout (1..255).

Ports:
- `clk` in 1: rising-edge clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `uinstr` in 45: microinstruction currently read from the microstore at `index`.
- `moc` in 1: memory operation complete.
- `cond_pass` in 1: the ARM condition-code test passed.
- `ccz` in 1: Z flag.
- `decode_addr` in 7: dispatch target from the instruction decoder.
- `decode_valid` in 1: `decode_addr` is valid.
- `stall` in 1: freeze sequencing.
- `index` out 7: registered micro-PC; addresses the microstore.
- `ctrl` out 31: `uinstr[44:14]`, combinational passthrough.
- `waiting` out 1: the current word is a wait or dispatch that is holding.
- `stk_ovf`, `stk_unf`, `wait_tmo` out 1 each: sticky error flags.

## Operation
Microinstruction fields:
- `uinstr[6:0]`: CR (target address).
- `uinstr[9:7]`: NS (next-address select).
- `uinstr[12:10]`: CS (condition select).
- `uinstr[13]`: INV (condition invert).

Condition:
- `cond = sel(CS) ^ INV`.
- CS values: 0 → 1, 1 → `moc`, 2 → `ccz`, 3 → `cond_pass`, 4 → `decode_valid`, 5–7 → 0.

NS next-address select:
- 0 INC: `index+1`.
- 1 JMP: CR.
- 2 BR: if `cond`, CR; otherwise `index+1`.
- 3 DISP: if `decode_valid`, `decode_addr`; otherwise hold `index` (`waiting`=1).
- 4 CALL: push `index+1`, then CR.
- 5 RET: pop into `index`.
- 6 WAIT: while `moc`=0, hold (`waiting`=1) and increment the wait counter; when `moc`=1, `index+1` and clear the counter.
- 7 RST: go to 0 and clear the wait counter. Stack is not cleared.

Arithmetic and width rules:
- The increment is 7-bit modulo; 127 wraps to 0 with no flag.

Return stack:
- LIFO, pointer `sp` in 0..`STACK_DEPTH`.
- CALL with `sp`=`STACK_DEPTH`: the push is suppressed, the jump to CR still occurs, and `stk_ovf` sets.
- RET with `sp`=0: next is 0 and `stk_unf` sets.

Wait timeout:
- When the counter reaches `WAIT_LIMIT` while still waiting, the next index is 0, `wait_tmo` sets, and the counter clears.

Stall:
- `stall`=1 holds `index`, `sp`, stack contents and the wait counter.
- No flags change during a stall. `ctrl` still follows `uinstr`.

Flags:
- All error flags are sticky until reset.

## Timing
- Reset (async, `rst_n`=0): `index`=0, `sp`=0, wait counter 0, all flags 0, `waiting`=0.
- `ctrl` reflects the microstore word 0 during reset.
- Next address is computed combinationally from `uinstr` and inputs, and registered at the rising edge. One microinstruction executes per cycle.
- `waiting` is combinational from the current NS, `moc` and `decode_valid`.
- The first rising edge after `rst_n` deasserts executes word 0.
- `moc` is sampled in the same cycle as WAIT: if `moc`=1 in the first WAIT cycle, zero extra cycles are spent.
- Timeout: with `moc` stuck at 0, WAIT occupies exactly `WAIT_LIMIT`+1 cycles. The edge after that goes to 0.
- Reset mid-wait or mid-call: everything returns to reset values immediately. Stack contents become don't-care.

## Structure
- Package `ctrl_pkg`:
  - field positions (`CR_LSB`, `NS_LSB`, `CS_LSB`, `INV_BIT`, `CTRL_LSB`);
  - NS enum (`NS_INC`, `NS_JMP`, `NS_BR`, `NS_DISP`, `NS_CALL`, `NS_RET`, `NS_WAIT`, `NS_RST`);
  - CS enum;
  - widths (`UADDR_W`=7, `UINSTR_W`=45).
- One sub-module, `ustack`: a parameterized return-address LIFO with push, pop, `sp`, `full` and `empty`.
- Next-address mux, condition mux and wait counter live in `microsequencer`.

## Test plan
- Reset, then `uinstr` with NS=INC everywhere → `index` goes 0,1,2,3 on successive edges. With `index`=127, the next value is 0.
- BR with CR=0x40, CS=3: `cond_pass`=1 → `index`=0x40. `cond_pass`=0 with INV=1 → 0x40. `cond_pass`=0 with INV=0 → `index+1`.
- WAIT at `index`=0x10, `moc`=0 for 3 cycles, then 1 → `index` holds 0x10 with `waiting`=1 for 3 cycles, then 0x11.
- WAIT with `WAIT_LIMIT`=4 and `moc` held 0 → after 5 cycles at the WAIT word, `index`=0 and `wait_tmo`=1 until reset.
- CALL from 0x05 to 0x50, then RET → `index` goes 0x50, then 0x06. Five nested CALLs with `STACK_DEPTH`=4 → `stk_ovf`=1. RET on an empty stack → `index`=0 and `stk_unf`=1.
- DISP with `decode_valid`=0 for 2 cycles, then `decode_addr`=0x2A valid → hold 2 cycles, then `index`=0x2A. `stall`=1 during DISP → `index` frozen and no flag change. Async `rst_n` pulse mid-sequence → `index`=0 immediately.
